// File: rtl/inter_tile_scheduler.sv
// Command sequencer for the intermediate stage: walks tm/tn/tk tiles and issues
// LOAD_A, LOAD_K, COMPUTE and STORE commands, one outstanding at a time.
module inter_tile_scheduler #(
    parameter int unsigned ROWS   = 8,
    parameter int unsigned COLS   = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TILE_M = 4,
    parameter int unsigned TILE_N = 4,
    parameter int unsigned TILE_K = 4,
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_A,
    input  logic [ADDR_W-1:0] addr_K,
    input  logic [ADDR_W-1:0] addr_G,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_op,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [31:0]       cmd_stride,
    output logic              cmd_first,
    output logic              cmd_last,
    input  logic              resp_valid,
    input  logic              resp_err
);

    localparam int unsigned CNT_W = 16;

    localparam logic [CNT_W-1:0] TM_LAST = CNT_W'(ROWS / TILE_M - 1);
    localparam logic [CNT_W-1:0] TN_LAST = CNT_W'(COLS / TILE_N - 1);
    localparam logic [CNT_W-1:0] TK_LAST = CNT_W'(DEPTH / TILE_K - 1);

    // Per-counter byte increments of each tile base address.
    localparam logic [ADDR_W-1:0] A_TM_STEP = ADDR_W'(TILE_M * DEPTH * 4);
    localparam logic [ADDR_W-1:0] A_TK_STEP = ADDR_W'(TILE_K * 4);
    localparam logic [ADDR_W-1:0] K_TK_STEP = ADDR_W'(TILE_K * COLS * 4);
    localparam logic [ADDR_W-1:0] G_TM_STEP = ADDR_W'(TILE_M * COLS * 4);
    localparam logic [ADDR_W-1:0] N_STEP    = ADDR_W'(TILE_N * 4);

    localparam logic [31:0] STRIDE_A  = 32'(DEPTH * 4);
    localparam logic [31:0] STRIDE_KG = 32'(COLS * 4);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StErr} state_e;
    typedef enum logic [1:0] {OpLoadA, OpLoadK, OpCompute, OpStore} op_e;

    state_e            state_q;
    op_e               op_q;
    logic [CNT_W-1:0]  tm_q, tn_q, tk_q;
    logic [ADDR_W-1:0] base_a_q, base_k_q, base_g_q;

    // Successor of the current substate.
    op_e               nxt_op;
    logic [CNT_W-1:0]  nxt_tm, nxt_tn, nxt_tk;
    logic              seq_end;

    always_comb begin
        nxt_op  = op_q;
        nxt_tm  = tm_q;
        nxt_tn  = tn_q;
        nxt_tk  = tk_q;
        seq_end = 1'b0;
        unique case (op_q)
            OpLoadA: nxt_op = OpLoadK;
            OpLoadK: nxt_op = OpCompute;
            OpCompute: begin
                if (tk_q == TK_LAST) begin
                    nxt_op = OpStore;
                end else begin
                    nxt_op = OpLoadA;
                    nxt_tk = tk_q + CNT_W'(1);
                end
            end
            OpStore: begin
                nxt_op = OpLoadA;
                nxt_tk = '0;
                if (tn_q == TN_LAST) begin
                    nxt_tn = '0;
                    if (tm_q == TM_LAST) begin
                        seq_end = 1'b1;
                    end else begin
                        nxt_tm = tm_q + CNT_W'(1);
                    end
                end else begin
                    nxt_tn = tn_q + CNT_W'(1);
                end
            end
            default: nxt_op = OpLoadA;
        endcase
    end

    // Substate and bases for the command about to be loaded: a fresh run uses the
    // start-time addresses directly since the latched copies are not yet valid.
    logic              accept_start;
    op_e               sel_op;
    logic [CNT_W-1:0]  sel_tm, sel_tn, sel_tk;
    logic [ADDR_W-1:0] sel_a, sel_k, sel_g;

    assign accept_start = start &&
        (state_q == StIdle || state_q == StDone || state_q == StErr);

    always_comb begin
        if (accept_start) begin
            sel_op = OpLoadA;
            sel_tm = '0;
            sel_tn = '0;
            sel_tk = '0;
            sel_a  = addr_A;
            sel_k  = addr_K;
            sel_g  = addr_G;
        end else begin
            sel_op = nxt_op;
            sel_tm = nxt_tm;
            sel_tn = nxt_tn;
            sel_tk = nxt_tk;
            sel_a  = base_a_q;
            sel_k  = base_k_q;
            sel_g  = base_g_q;
        end
    end

    logic [ADDR_W-1:0] fld_addr;
    logic [31:0]       fld_stride;
    logic              fld_first, fld_last;

    always_comb begin
        fld_addr   = '0;
        fld_stride = '0;
        fld_first  = 1'b0;
        fld_last   = 1'b0;
        unique case (sel_op)
            OpLoadA: begin
                fld_addr   = sel_a + ADDR_W'(sel_tm) * A_TM_STEP + ADDR_W'(sel_tk) * A_TK_STEP;
                fld_stride = STRIDE_A;
            end
            OpLoadK: begin
                fld_addr   = sel_k + ADDR_W'(sel_tk) * K_TK_STEP + ADDR_W'(sel_tn) * N_STEP;
                fld_stride = STRIDE_KG;
            end
            OpCompute: begin
                fld_first = (sel_tk == '0);
                fld_last  = (sel_tk == TK_LAST);
            end
            OpStore: begin
                fld_addr   = sel_g + ADDR_W'(sel_tm) * G_TM_STEP + ADDR_W'(sel_tn) * N_STEP;
                fld_stride = STRIDE_KG;
            end
            default: fld_addr = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= OpLoadA;
            tm_q       <= '0;
            tn_q       <= '0;
            tk_q       <= '0;
            base_a_q   <= '0;
            base_k_q   <= '0;
            base_g_q   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_op     <= 2'd0;
            cmd_addr   <= '0;
            cmd_stride <= '0;
            cmd_first  <= 1'b0;
            cmd_last   <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone, StErr: begin
                    if (accept_start) begin
                        state_q    <= StIssue;
                        op_q       <= sel_op;
                        tm_q       <= sel_tm;
                        tn_q       <= sel_tn;
                        tk_q       <= sel_tk;
                        base_a_q   <= addr_A;
                        base_k_q   <= addr_K;
                        base_g_q   <= addr_G;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        cmd_valid  <= 1'b1;
                        cmd_op     <= sel_op;
                        cmd_addr   <= fld_addr;
                        cmd_stride <= fld_stride;
                        cmd_first  <= fld_first;
                        cmd_last   <= fld_last;
                    end
                end
                StIssue: begin
                    if (cmd_ready) begin
                        state_q   <= StWait;
                        cmd_valid <= 1'b0;
                    end
                end
                StWait: begin
                    if (resp_valid) begin
                        if (resp_err) begin
                            state_q <= StErr;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            error   <= 1'b1;
                        end else if (seq_end) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_q    <= StIssue;
                            op_q       <= sel_op;
                            tm_q       <= sel_tm;
                            tn_q       <= sel_tn;
                            tk_q       <= sel_tk;
                            cmd_valid  <= 1'b1;
                            cmd_op     <= sel_op;
                            cmd_addr   <= fld_addr;
                            cmd_stride <= fld_stride;
                            cmd_first  <= fld_first;
                            cmd_last   <= fld_last;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/inter_tile_scheduler.md
# inter_tile_scheduler

Command sequencer for the intermediate stage (A~ × K'^T → requant → GELU → requant → G~). It breaks the ROWS×COLS output into TILE_M×TILE_N tiles and walks the DEPTH reduction in TILE_K steps. For each tile it issues LOAD_A, LOAD_K, COMPUTE and STORE commands, with DDR addresses, to the tile datapath (DMA readers, MAC array, requant/GELU, writer). It sits between the top-level start/done/error controls and the datapath's command port, and keeps one command outstanding at a time.

## Interface
Parameters:
- ROWS, 8: rows of A and G.
- COLS, 16: columns of K and G.
- DEPTH, 8: reduction length.
- TILE_M, 4: output tile height; must divide ROWS.
- TILE_N, 4: output tile width; must divide COLS.
- TILE_K, 4: reduction step; must divide DEPTH.
- ADDR_W, 64: address width.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE, DONE or ERR.
- addr_A, addr_K, addr_G  in  ADDR_W each  byte base addresses; latched on accepted start.
- busy  out  1  high from the cycle after accepted start until DONE or ERR.
- done  out  1  level; high in DONE or ERR; cleared by accepted start or rst.
- error  out  1  level; high only in ERR; cleared by accepted start or rst.
- cmd_valid  out  1  command offered.
- cmd_ready  in  1  datapath accepts command.
- cmd_op  out  2  0=LOAD_A, 1=LOAD_K, 2=COMPUTE, 3=STORE.
- cmd_addr  out  ADDR_W  tile base byte address; 0 for COMPUTE.
- cmd_stride  out  32  byte row stride; 0 for COMPUTE.
- cmd_first  out  1  COMPUTE only: clear the accumulator (tk==0).
- cmd_last  out  1  COMPUTE only: final reduction step (tk==DEPTH/TILE_K−1).
- resp_valid  in  1  completion of the outstanding command.
- resp_err  in  1  qualifies resp_valid; the command failed.

## Operation
- Each element occupies one 32-bit word (4 bytes), row-major in DDR.
- Loop order is tm outer, tn middle, tk inner. For each (tm, tn):
  - For each tk: LOAD_A, then LOAD_K, then COMPUTE.
  - After the last tk: STORE.
- Address arithmetic, computed in ADDR_W bits with no wrap checking:
  - LOAD_A: cmd_addr = addr_A + ((tm·TILE_M)·DEPTH + tk·TILE_K)·4; cmd_stride = DEPTH·4.
  - LOAD_K: cmd_addr = addr_K + ((tk·TILE_K)·COLS + tn·TILE_N)·4; cmd_stride = COLS·4.
  - STORE: cmd_addr = addr_G + ((tm·TILE_M)·COLS + tn·TILE_N)·4; cmd_stride = COLS·4.
- Commands per run: (ROWS/TILE_M)·(COLS/TILE_N)·(3·DEPTH/TILE_K + 1).
- States: IDLE, ISSUE, WAIT, DONE, ERR. The current op and the tm/tn/tk counters form the sequencing substate.
  - IDLE/DONE/ERR + start → ISSUE. Counters reset to 0, op=LOAD_A, addresses latched, done and error cleared.
  - ISSUE: cmd_valid=1. On cmd_ready → WAIT.
  - WAIT, resp_valid with resp_err=0: advance op/counters → ISSUE. After the final STORE → DONE.
  - WAIT, resp_valid with resp_err=1 → ERR. The sequence is abandoned.
- resp_valid outside WAIT is ignored.
- start in ISSUE or WAIT is ignored.
- rst at any point returns the block to IDLE and discards the in-flight command. The datapath must be reset alongside it.

## Timing
- Reset values: busy=0, done=0, error=0, cmd_valid=0, cmd_op=0, cmd_addr=0, cmd_stride=0, cmd_first=0, cmd_last=0. State is IDLE.
- start accepted at edge N: cmd_valid=1 with the first LOAD_A fields at N+1; busy=1 at N+1.
- All cmd_* outputs are registered and held stable while cmd_valid=1 and cmd_ready=0.
- Handshake at edge H (cmd_valid & cmd_ready): cmd_valid=0 at H+1.
- cmd_ready may be high before cmd_valid; acceptance needs both signals in the same cycle.
- resp_valid at edge R in WAIT: the next command is valid at R+1. Minimum command period is 2 cycles when ready and resp arrive immediately.
- resp_valid in the same cycle as the handshake is not a completion; it is ignored.
- Final STORE resp at R: done=1, busy=0 at R+1.
- Error resp at R: done=1, error=1, busy=0 at R+1.
- start and rst in the same cycle: rst wins.

## Test plan
- Default parameters, cmd_ready tied high, resp one cycle after each handshake, addr_A=0x1000, addr_K=0x2000, addr_G=0x3000:
  - exactly 56 commands;
  - first is LOAD_A 0x1000 stride 32;
  - second is LOAD_K 0x2000 stride 64;
  - third is COMPUTE first=1 last=0;
  - sixth is COMPUTE first=0 last=1;
  - seventh is STORE 0x3000 stride 64;
  - last is STORE 0x3000+(4·16+12)·4 = 0x3130;
  - done=1 one cycle after the final resp.
- Random cmd_ready back-pressure, 0–7 stall cycles: cmd_* stable while stalled; the command sequence matches the first scenario.
- resp_err=1 on the 10th response: done=1, error=1, busy=0 next cycle; no further cmd_valid. A subsequent start clears error and reruns all 56 commands.
- Spurious resp_valid in ISSUE, and start pulsed mid-run: no effect on sequence, counters or outputs.
- rst asserted during WAIT of the 20th command: all outputs at reset values next cycle. A fresh start begins again at LOAD_A addr_A.
- TILE_M=ROWS, TILE_N=COLS, TILE_K=DEPTH: exactly 4 commands (LOAD_A, LOAD_K, COMPUTE first=1 last=1, STORE addr_G).
